// File: rtl/atm_access_ctrl.sv
// Access controller for the ATM front end: turns button presses into one-shot
// commands and enforces password/insufficient-funds lockouts.
module atm_access_ctrl #(
    parameter int LONG_LOCK  = 100,
    parameter int SHORT_LOCK = 50,
    parameter int MAX_TRIES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTN1,
    input  logic       BTN2,
    input  logic       BTN3,
    input  logic       pw_ok,
    input  logic       pw_fail,
    input  logic       funds_fail,
    output logic       cmd_valid,
    output logic [1:0] cmd_sel,
    output logic       locked,
    output logic       lock_long,
    output logic       force_logout,
    output logic [1:0] tries_left,
    output logic [7:0] lock_remaining
);

    typedef enum logic [1:0] {
        READY      = 2'd0,
        LOCK_SHORT = 2'd1,
        LOCK_LONG  = 2'd2
    } state_t;

    localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);
    localparam logic [7:0] LONG_LEN   = 8'(LONG_LOCK);
    localparam logic [7:0] SHORT_LEN  = 8'(SHORT_LOCK);

    state_t     state, state_nxt;
    logic [2:0] btn_cur, btn_prev, btn_rise;
    logic [1:0] tries_nxt;
    logic [7:0] rem_nxt;
    logic       cmd_valid_nxt;
    logic [1:0] cmd_sel_nxt;
    logic       force_logout_nxt;

    // Lowest index wins: BTN1 > BTN2 > BTN3.
    function automatic logic [1:0] pick_cmd(input logic [2:0] rise);
        logic [1:0] sel;
        sel = 2'd0;
        if (rise[0])      sel = 2'd1;
        else if (rise[1]) sel = 2'd2;
        else if (rise[2]) sel = 2'd3;
        return sel;
    endfunction

    assign btn_cur   = {BTN3, BTN2, BTN1};
    assign btn_rise  = btn_cur & ~btn_prev;
    assign locked    = (state != READY);
    assign lock_long = (state == LOCK_LONG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= READY;
            btn_prev       <= 3'b000;
            tries_left     <= TRIES_INIT;
            lock_remaining <= 8'd0;
            cmd_valid      <= 1'b0;
            cmd_sel        <= 2'd0;
            force_logout   <= 1'b0;
        end else begin
            state          <= state_nxt;
            btn_prev       <= btn_cur;
            tries_left     <= tries_nxt;
            lock_remaining <= rem_nxt;
            cmd_valid      <= cmd_valid_nxt;
            cmd_sel        <= cmd_sel_nxt;
            force_logout   <= force_logout_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        tries_nxt        = tries_left;
        rem_nxt          = lock_remaining;
        cmd_valid_nxt    = 1'b0;
        cmd_sel_nxt      = 2'd0;
        force_logout_nxt = 1'b0;

        case (state)
            READY: begin
                // A coincident pw_fail overrides pw_ok.
                if (pw_ok && !pw_fail) begin
                    tries_nxt = TRIES_INIT;
                end
                if (pw_fail) begin
                    if (tries_left <= 2'd1) begin
                        state_nxt        = LOCK_LONG;
                        rem_nxt          = LONG_LEN;
                        tries_nxt        = TRIES_INIT;
                        force_logout_nxt = 1'b1;
                    end else begin
                        tries_nxt = tries_left - 2'd1;
                    end
                end
                if (funds_fail && state_nxt == READY) begin
                    state_nxt = LOCK_SHORT;
                    rem_nxt   = SHORT_LEN;
                end
                // No command on the edge that enters a lock, so cmd_valid never overlaps locked.
                if (state_nxt == READY && btn_rise != 3'b000) begin
                    cmd_valid_nxt = 1'b1;
                    cmd_sel_nxt   = pick_cmd(btn_rise);
                end
            end
            LOCK_SHORT, LOCK_LONG: begin
                if (lock_remaining <= 8'd1) begin
                    state_nxt = READY;
                    rem_nxt   = 8'd0;
                end else begin
                    rem_nxt = lock_remaining - 8'd1;
                end
            end
            default: begin
                state_nxt = READY;
                rem_nxt   = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_atm_access_ctrl.sv
// Bench for atm_access_ctrl: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a cycle-count based model.
module tb_atm_access_ctrl;

    localparam int LONG_LOCK  = 100;
    localparam int SHORT_LOCK = 50;
    localparam int MAX_TRIES  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       BTN1 = 1'b0, BTN2 = 1'b0, BTN3 = 1'b0;
    logic       pw_ok = 1'b0, pw_fail = 1'b0, funds_fail = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_sel;
    logic       locked, lock_long, force_logout;
    logic [1:0] tries_left;
    logic [7:0] lock_remaining;

    int n_chk  = 0;
    int n_fail = 0;

    atm_access_ctrl #(
        .LONG_LOCK (LONG_LOCK),
        .SHORT_LOCK(SHORT_LOCK),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .BTN1          (BTN1),
        .BTN2          (BTN2),
        .BTN3          (BTN3),
        .pw_ok         (pw_ok),
        .pw_fail       (pw_fail),
        .funds_fail    (funds_fail),
        .cmd_valid     (cmd_valid),
        .cmd_sel       (cmd_sel),
        .locked        (locked),
        .lock_long     (lock_long),
        .force_logout  (force_logout),
        .tries_left    (tries_left),
        .lock_remaining(lock_remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Model: a lock is an interval of cycle numbers [start, m_until).
    int         m_cyc   = 0;
    int         m_until = 0;
    int         m_tries = MAX_TRIES;
    bit         m_long  = 1'b0;
    logic [2:0] m_prev  = 3'b000;
    bit         m_cmd   = 1'b0;
    int         m_sel   = 0;
    bit         m_fl    = 1'b0;
    bit         m_ready, m_enter;
    logic [2:0] m_btn, m_rise;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc = 0; m_until = 0; m_tries = MAX_TRIES; m_long = 1'b0;
            m_prev = 3'b000; m_cmd = 1'b0; m_sel = 0; m_fl = 1'b0;
        end else begin
            m_ready = (m_cyc >= m_until);
            m_cyc++;
            m_cmd = 1'b0; m_sel = 0; m_fl = 1'b0; m_enter = 1'b0;
            m_btn  = {BTN3, BTN2, BTN1};
            m_rise = m_btn & ~m_prev;
            m_prev = m_btn;
            if (m_ready) begin
                if (pw_ok && !pw_fail) m_tries = MAX_TRIES;
                if (pw_fail) begin
                    m_tries = m_tries - 1;
                    if (m_tries == 0) begin
                        m_tries = MAX_TRIES;
                        m_until = m_cyc + LONG_LOCK;
                        m_long  = 1'b1;
                        m_fl    = 1'b1;
                        m_enter = 1'b1;
                    end
                end
                if (funds_fail && !m_enter) begin
                    m_until = m_cyc + SHORT_LOCK;
                    m_long  = 1'b0;
                    m_enter = 1'b1;
                end
                if (!m_enter && m_rise != 3'b000) begin
                    m_cmd = 1'b1;
                    m_sel = m_rise[0] ? 1 : (m_rise[1] ? 2 : 3);
                end
            end
        end
    end

    // Per-cycle compare against the model.
    bit e_lock;
    always @(negedge clk) begin
        e_lock = (m_cyc < m_until);
        chk("cmd_valid", cmd_valid, m_cmd);
        chk("cmd_sel", cmd_sel, m_sel);
        chk("locked", locked, e_lock);
        chk("lock_long", lock_long, e_lock && m_long);
        chk("force_logout", force_logout, m_fl);
        chk("tries_left", tries_left, m_tries);
        chk("lock_remaining", lock_remaining, e_lock ? (m_until - m_cyc) : 0);
        chk("no_cmd_while_locked", cmd_valid && locked, 0);
    end

    // Event recorder for the directed scenarios.
    int cmds[$];
    int lock_cnt = 0, long_cnt = 0, fl_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (cmd_valid) cmds.push_back(int'(cmd_sel));
            if (locked) lock_cnt++;
            if (lock_long) long_cnt++;
            if (force_logout) fl_cnt++;
        end
    end

    task automatic clear_rec();
        cmds.delete();
        lock_cnt = 0; long_cnt = 0; fl_cnt = 0;
    endtask

    task automatic pulse_fail();
        pw_fail = 1'b1; tick(); pw_fail = 1'b0; tick();
    endtask

    initial begin
        int k;
        repeat (3) tick();
        chk("rst_locked", locked, 0);
        chk("rst_tries", tries_left, 3);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_lock_rem", lock_remaining, 0);
        rst = 1'b1;
        repeat (2) tick();

        // BTN3 tap then BTN1 held: two commands, 3 then 1.
        clear_rec();
        BTN3 = 1'b1; tick(); BTN3 = 1'b0;
        BTN1 = 1'b1; repeat (5) tick(); BTN1 = 1'b0;
        repeat (3) tick();
        chk("s34_count", cmds.size(), 2);
        if (cmds.size() == 2) begin
            chk("s34_first", cmds[0], 3);
            chk("s34_second", cmds[1], 1);
        end

        // BTN1 and BTN3 together: only BTN1.
        clear_rec();
        BTN1 = 1'b1; BTN3 = 1'b1; repeat (4) tick();
        BTN1 = 1'b0; BTN3 = 1'b0; repeat (3) tick();
        chk("s35_count", cmds.size(), 1);
        if (cmds.size() == 1) chk("s35_sel", cmds[0], 1);

        // Three password failures -> 100-cycle long lock.
        clear_rec();
        chk("s36_tries0", tries_left, 3);
        pulse_fail(); chk("s36_tries1", tries_left, 2);
        pulse_fail(); chk("s36_tries2", tries_left, 1);
        pulse_fail(); chk("s36_tries3", tries_left, 3);
        for (int i = 0; i < 10; i++) begin
            BTN3 = 1'b1; tick(); BTN3 = 1'b0; tick();
        end
        repeat (100) tick();
        chk("s36_locked_cycles", lock_cnt, 100);
        chk("s36_long_cycles", long_cnt, 100);
        chk("s36_force_logout", fl_cnt, 1);
        chk("s36_no_cmds", cmds.size(), 0);

        // fail, fail, ok, fail -> no lock, two tries left.
        clear_rec();
        pulse_fail(); pulse_fail();
        pw_ok = 1'b1; tick(); pw_ok = 1'b0; tick();
        pulse_fail(); tick();
        chk("s37_tries", tries_left, 2);
        chk("s37_no_lock", lock_cnt, 0);

        // Insufficient funds -> 50-cycle short lock; held button gives nothing.
        clear_rec();
        funds_fail = 1'b1; tick(); funds_fail = 1'b0;
        repeat (10) tick();
        BTN1 = 1'b1; repeat (50) tick();
        chk("s38_locked_cycles", lock_cnt, 50);
        chk("s38_long_cycles", long_cnt, 0);
        chk("s38_tries", tries_left, 2);
        chk("s38_no_cmd_held", cmds.size(), 0);
        BTN1 = 1'b0; tick();
        BTN1 = 1'b1; repeat (2) tick(); BTN1 = 1'b0; tick();
        chk("s38_fresh_count", cmds.size(), 1);
        if (cmds.size() == 1) chk("s38_fresh_sel", cmds[0], 1);

        // Reset in the middle of a long lock.
        pulse_fail(); pulse_fail();
        k = 0;
        while (lock_remaining != 8'd40 && k < 300) begin
            tick();
            k++;
        end
        chk("s39_reached_rem40", lock_remaining, 40);
        rst = 1'b0;
        #1;
        chk("s39_locked_async", locked, 0);
        chk("s39_tries_async", tries_left, 3);
        chk("s39_rem_async", lock_remaining, 0);
        BTN3 = 1'b1;
        repeat (2) tick();
        clear_rec();
        rst = 1'b1;
        repeat (3) tick();
        chk("s33_held_count", cmds.size(), 1);
        if (cmds.size() == 1) chk("s33_held_sel", cmds[0], 3);
        BTN3 = 1'b0; tick();
        clear_rec();
        BTN2 = 1'b1; repeat (2) tick(); BTN2 = 1'b0; tick();
        chk("s39_cmd_count", cmds.size(), 1);
        if (cmds.size() == 1) chk("s39_cmd_sel", cmds[0], 2);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 3) == 0) BTN1 = ~BTN1;
            if ($urandom_range(0, 3) == 0) BTN2 = ~BTN2;
            if ($urandom_range(0, 3) == 0) BTN3 = ~BTN3;
            pw_ok      = ($urandom_range(0, 15) == 0);
            pw_fail    = ($urandom_range(0, 11) == 0);
            funds_fail = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0; tick(); tick(); rst = 1'b1;
            end
            tick();
        end
        pw_ok = 1'b0; pw_fail = 1'b0; funds_fail = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
